frame_store_ctrl: RTL and testbench
===================================

// Module: frame_store_ctrl
// PURPOSE
//  Writer/address side of the BRAM frame store. Captures one VGA frame of the processed pixel
//  stream into BRAM as RGB332, then generates read addresses for playback. Drives bram_state,
//  which pixel_sel consumes, and bram_dout (RGB332) returns to pixel_sel. Active during SAVE_TO_BRAM.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line stored (in_display: hcount<H_ACTIVE)
//  V_ACTIVE  400  active lines stored (in_display: vcount<V_ACTIVE)
//  ADDR_W    18   BRAM address width; H_ACTIVE*V_ACTIVE <= 2**ADDR_W required
// PORTS
//  clk          in   1       pixel clock
//  reset        in   1       synchronous, active-low reset
//  capture_req  in   1       1-cycle pulse: arm capture of next full frame
//  view_en      in   1       level: play stored frame (READING_FRAME) when not capturing
//  pixel_in     in   24      RGB888 pixel, aligned with hcount/vcount by the caller
//  hcount       in   11      VGA horizontal count
//  vcount       in   10      VGA vertical count
//  bram_addr    out  ADDR_W  BRAM address (write and read share the port)
//  bram_din     out  8       RGB332 write data
//  bram_we      out  1       BRAM write enable
//  bram_state   out  2       00 BRAM_IDLE, 01 CAPTURE_FRAME, 10 WRITING_FRAME, 11 READING_FRAME
//  busy         out  1       1 in CAPTURE_FRAME or WRITING_FRAME
//  done         out  1       1-cycle pulse, coincident with the final frame write
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0 at clk edge): state=BRAM_IDLE, bram_addr=0,
//    bram_din=0, bram_we=0, busy=0, done=0, write counter=0. Mid-frame reset abandons the
//    capture; partial BRAM contents are not cleared.
//  - RGB332 pack: bram_din = {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]}.
//  - in_disp = (hcount<H_ACTIVE)&&(vcount<V_ACTIVE); fs = (hcount==0)&&(vcount==0).
//  - FRAME_PIXELS = H_ACTIVE*V_ACTIVE (localparam). Write counter wcnt is ADDR_W bits.
//  - BRAM_IDLE: capture_req -> CAPTURE_FRAME (wcnt<=0); else view_en -> READING_FRAME.
//    bram_we=0.
//  - CAPTURE_FRAME: wait for fs. On the fs cycle -> WRITING_FRAME and that pixel is written:
//    next cycle bram_we=1, bram_addr=0, bram_din=pack(pixel_in), wcnt<=1.
//  - WRITING_FRAME: each in_disp cycle -> next cycle bram_we=1, bram_addr=wcnt,
//    bram_din=pack(pixel_in), wcnt<=wcnt+1; non-in_disp cycles -> bram_we=0, addr held.
//    Write latency 1 clk from pixel. The write to FRAME_PIXELS-1 asserts done the same cycle
//    and the state leaves WRITING_FRAME: -> READING_FRAME if view_en, else BRAM_IDLE.
//  - READING_FRAME: bram_we=0; bram_addr <= in_disp ? vcount*H_ACTIVE+hcount : 0 (1-clk
//    latency; the BRAM read adds its own, absorbed downstream). view_en==0 -> BRAM_IDLE.
//    capture_req -> CAPTURE_FRAME (capture has priority over view).
//  - capture_req during CAPTURE_FRAME/WRITING_FRAME is ignored; there is no restart.
//    view_en changes are ignored until the write completes.
//  - capture_req and view_en both high in BRAM_IDLE: capture wins.
//  - A capture armed mid-frame waits for the next fs. No partial frame is written.
//  - busy = (state==01)||(state==10), registered together with state.
//  - No wrap: wcnt never exceeds FRAME_PIXELS-1. Read address never exceeds FRAME_PIXELS-1.
// TESTING  (sim params H_ACTIVE=8, V_ACTIVE=4, ADDR_W=5; 12x6 raster, pixel_in = f(h,v))
//  1 reset=0 for 3 clks with random inputs -> bram_state=00, we=0, addr=0, din=0, busy=0, done=0
//  2 capture_req at (h=5,v=2) -> state 01 until fs; then exactly 32 writes, addrs 0..31 in
//    raster order, none at h>=8 or v>=4; done high only with addr=31; state 00 afterwards
//  3 pixel_in=24'hE0E0C0 at (0,0) -> first write din=8'hFF; 24'h1F1F3F -> din=8'h00
//  4 view_en=1 after capture -> state 11; at (h=3,v=2) next-cycle addr=19; at h=9 addr=0;
//    view_en=0 -> state 00
//  5 capture_req+view_en same cycle in 00 -> 01; second capture_req at write 10 -> ignored,
//    writes continue to 31, done once
//  6 reset=0 at write 20 -> next cycle state 00, we=0; new capture_req -> restart at addr 0

Source files
------------

// File: rtl/frame_store_ctrl.sv
// frame_store_ctrl
//   Writer/address side of the BRAM frame store. Captures one full frame of the
//   processed RGB888 pixel stream into BRAM as RGB332, then generates raster
//   read addresses for playback of the stored frame.
//
//   state         | meaning
//   --------------+---------------------------------------------------------
//   BRAM_IDLE     | nothing in progress; BRAM untouched
//   CAPTURE_FRAME | capture armed, waiting for the next frame start (0,0)
//   WRITING_FRAME | writing active pixels of the frame, raster order
//   READING_FRAME | playback: address follows hcount/vcount
//
// Ports
//   i_clk          pixel clock
//   i_reset        synchronous reset, active low
//   i_capture_req  1-cycle pulse, arms capture of the next full frame
//   i_view_en      level, play the stored frame when not capturing
//   i_pixel_in     RGB888 pixel aligned with i_hcount/i_vcount
//   i_hcount       VGA horizontal count
//   i_vcount       VGA vertical count
//   o_bram_addr    shared BRAM write/read address
//   o_bram_din     RGB332 write data
//   o_bram_we      BRAM write enable
//   o_bram_state   current state encoding (see table)
//   o_busy         high while capturing or writing
//   o_done         1-cycle pulse together with the final frame write
module frame_store_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 400,
  parameter int ADDR_W   = 18
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_capture_req,
  input  logic              i_view_en,
  input  logic [23:0]       i_pixel_in,
  input  logic [10:0]       i_hcount,
  input  logic [9:0]        i_vcount,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [7:0]        o_bram_din,
  output logic              o_bram_we,
  output logic [1:0]        o_bram_state,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } state_t;

  localparam logic [10:0]       H_LIM      = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM      = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [7:0]        r_din,   w_din_nxt;
  logic              r_we,    w_we_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_done,  w_done_nxt;
  logic [ADDR_W-1:0] r_wcnt,  w_wcnt_nxt;

  logic              w_in_disp;
  logic              w_fs;
  logic [7:0]        w_pack;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_wr_go;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_wr_last;
  logic              w_unused;

  assign w_in_disp = (i_hcount < H_LIM) && (i_vcount < V_LIM);
  assign w_fs      = (i_hcount == '0) && (i_vcount == '0);
  assign w_pack    = {i_pixel_in[23:21], i_pixel_in[15:13], i_pixel_in[7:6]};
  assign w_unused  = ^{i_pixel_in[20:16], i_pixel_in[12:8], i_pixel_in[5:0]};

  // Only used while in_disp, so both counts are below their active limits and
  // the truncation to ADDR_W cannot lose significant bits.
  assign w_raddr = ADDR_W'(i_vcount) * ADDR_W'(H_ACTIVE) + ADDR_W'(i_hcount);

  // The frame-start pixel is written from CAPTURE_FRAME at index 0; every
  // later active pixel comes from WRITING_FRAME at the running count.
  assign w_wr_go   = ((r_state == CAPTURE_FRAME) && w_fs) ||
                     ((r_state == WRITING_FRAME) && w_in_disp);
  assign w_wr_idx  = (r_state == CAPTURE_FRAME) ? '0 : r_wcnt;
  assign w_wr_last = (w_wr_idx == LAST_PIXEL);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_wcnt_nxt  = r_wcnt;

    case (r_state)
      BRAM_IDLE: begin
        if (i_capture_req) begin
          w_state_nxt = CAPTURE_FRAME;
          w_wcnt_nxt  = '0;
        end else if (i_view_en) begin
          w_state_nxt = READING_FRAME;
        end
      end
      CAPTURE_FRAME: begin
        if (w_fs) w_state_nxt = WRITING_FRAME;
      end
      WRITING_FRAME: begin
      end
      READING_FRAME: begin
        w_addr_nxt = w_in_disp ? w_raddr : '0;
        if (i_capture_req) begin
          w_state_nxt = CAPTURE_FRAME;
          w_wcnt_nxt  = '0;
        end else if (!i_view_en) begin
          w_state_nxt = BRAM_IDLE;
        end
      end
      default: w_state_nxt = BRAM_IDLE;
    endcase

    if (w_wr_go) begin
      w_we_nxt   = 1'b1;
      w_addr_nxt = w_wr_idx;
      w_din_nxt  = w_pack;
      w_wcnt_nxt = w_wr_last ? '0 : w_wr_idx + ADDR_W'(1);
      if (w_wr_last) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = i_view_en ? READING_FRAME : BRAM_IDLE;
      end
    end

    w_busy_nxt = (w_state_nxt == CAPTURE_FRAME) || (w_state_nxt == WRITING_FRAME);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= BRAM_IDLE;
      r_addr  <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_we    <= w_we_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  assign o_bram_addr  = r_addr;
  assign o_bram_din   = r_din;
  assign o_bram_we    = r_we;
  assign o_bram_state = r_state;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_frame_store_ctrl.sv
// tb_frame_store_ctrl
//   Bench for frame_store_ctrl on a small 12x6 raster (8x4 active). Expected
//   writes are queued as captured pixels are driven and popped as the DUT
//   writes them; playback addresses and state are checked at chosen points.
module tb_frame_store_ctrl;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int AW   = 5;
  localparam int HT   = 12;
  localparam int VT   = 6;
  localparam int NPIX = H * V;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_capture_req;
  logic          i_view_en;
  logic [23:0]   i_pixel_in;
  logic [10:0]   i_hcount;
  logic [9:0]    i_vcount;
  logic [AW-1:0] o_bram_addr;
  logic [7:0]    o_bram_din;
  logic          o_bram_we;
  logic [1:0]    o_bram_state;
  logic          o_busy;
  logic          o_done;

  always #5 i_clk = ~i_clk;

  frame_store_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) u_dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_capture_req (i_capture_req),
    .i_view_en     (i_view_en),
    .i_pixel_in    (i_pixel_in),
    .i_hcount      (i_hcount),
    .i_vcount      (i_vcount),
    .o_bram_addr   (o_bram_addr),
    .o_bram_din    (o_bram_din),
    .o_bram_we     (o_bram_we),
    .o_bram_state  (o_bram_state),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          last;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cur_h, cur_v;
  logic [23:0] pix00;
  bit          armed, capturing;
  int          nexp;
  int          writes_seen;
  int          done_cnt;
  logic [7:0]  first_din;

  function automatic logic [7:0] pack(input logic [23:0] p);
    return {p[23:21], p[15:13], p[7:6]};
  endfunction

  function automatic logic [23:0] pix_f(input int h, input int v);
    if (h == 0 && v == 0) return pix00;
    return {8'(h * 37 + v * 11 + 1), 8'(v * 53 + h * 3), 8'(h * v * 7 + 5)};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_pos(input int h, input int v);
    wr_t e;
    cur_h      = h;
    cur_v      = v;
    i_hcount   = 11'(h);
    i_vcount   = 10'(v);
    i_pixel_in = pix_f(h, v);
    if (armed && h == 0 && v == 0) begin
      armed     = 1'b0;
      capturing = 1'b1;
      nexp      = 0;
    end
    if (capturing && h < H && v < V) begin
      e.addr = AW'(nexp);
      e.din  = pack(i_pixel_in);
      e.last = (nexp == NPIX - 1);
      exp_q.push_back(e);
      nexp++;
      if (nexp == NPIX) capturing = 1'b0;
    end
  endtask

  task automatic tick();
    wr_t e;
    int  h, v;
    @(posedge i_clk);
    #1;
    if (o_bram_we) begin
      if (exp_q.size() == 0) begin
        check_val("unexp_wr", 32'(o_bram_we), 0);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", 32'(o_bram_addr), 32'(e.addr));
        check_val("wr_din",  32'(o_bram_din),  32'(e.din));
        check_val("wr_done", 32'(o_done),      32'(e.last));
        if (e.addr == '0) first_din = o_bram_din;
        writes_seen++;
      end
    end else begin
      check_val("done_nowr", 32'(o_done), 0);
    end
    if (o_done) done_cnt++;
    h = cur_h + 1;
    v = cur_v;
    if (h == HT) begin
      h = 0;
      v = (v + 1 == VT) ? 0 : v + 1;
    end
    drive_pos(h, v);
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < 200 && !(cur_h == h && cur_v == v); i++) tick();
    check_val("wait_pos", 32'(cur_h == h && cur_v == v), 1);
  endtask

  task automatic run_to_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    check_val("done_seen", 32'(done_cnt - d0), 1);
  endtask

  task automatic pulse_capture(input bit expect_accept);
    i_capture_req = 1'b1;
    if (expect_accept) begin
      armed       = 1'b1;
      writes_seen = 0;
      first_din   = 8'hAA;
    end
    tick();
    i_capture_req = 1'b0;
  endtask

  initial begin
    int dc0;
    armed       = 1'b0;
    capturing   = 1'b0;
    nexp        = 0;
    writes_seen = 0;
    done_cnt    = 0;
    first_din   = 8'hAA;
    pix00       = 24'hE0E0C0;

    // reset held with random inputs
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_capture_req = 1'($urandom);
      i_view_en     = 1'($urandom);
      i_pixel_in    = 24'($urandom);
      i_hcount      = 11'($urandom);
      i_vcount      = 10'($urandom);
      @(posedge i_clk);
      #1;
    end
    check_val("rst_state", 32'(o_bram_state), 0);
    check_val("rst_we",    32'(o_bram_we),    0);
    check_val("rst_addr",  32'(o_bram_addr),  0);
    check_val("rst_din",   32'(o_bram_din),   0);
    check_val("rst_busy",  32'(o_busy),       0);
    check_val("rst_done",  32'(o_done),       0);

    i_reset       = 1'b1;
    i_capture_req = 1'b0;
    i_view_en     = 1'b0;
    drive_pos(0, 0);

    // capture armed mid-frame waits for frame start
    wait_pos(5, 2);
    pulse_capture(1'b1);
    check_val("cap_state", 32'(o_bram_state), 1);
    check_val("cap_busy",  32'(o_busy),       1);
    for (int i = 0; i < 100 && !(cur_h == 0 && cur_v == 0); i++) begin
      tick();
      check_val("cap_wait_state", 32'(o_bram_state), 1);
    end
    tick();
    check_val("wr_state", 32'(o_bram_state), 2);
    check_val("wr_busy",  32'(o_busy),       1);
    run_to_done();
    check_val("wr_count",    32'(writes_seen),  NPIX);
    check_val("q_empty",     32'(exp_q.size()), 0);
    check_val("done_state",  32'(o_bram_state), 0);
    check_val("done_busy",   32'(o_busy),       0);
    check_val("first_din_ff", 32'(first_din),   32'h00FF);
    tick();
    check_val("post_we",    32'(o_bram_we),    0);
    check_val("post_state", 32'(o_bram_state), 0);

    // playback addressing
    i_view_en = 1'b1;
    tick();
    check_val("view_state", 32'(o_bram_state), 3);
    wait_pos(3, 2);
    tick();
    check_val("rd_addr_19", 32'(o_bram_addr), 19);
    check_val("rd_we",      32'(o_bram_we),   0);
    wait_pos(9, 2);
    tick();
    check_val("rd_addr_h9", 32'(o_bram_addr), 0);
    i_view_en = 1'b0;
    tick();
    check_val("view_off_state", 32'(o_bram_state), 0);

    // capture beats view; re-request during write is ignored
    pix00     = 24'h1F1F3F;
    i_view_en = 1'b1;
    dc0       = done_cnt;
    pulse_capture(1'b1);
    check_val("cap_prio_state", 32'(o_bram_state), 1);
    for (int i = 0; i < 300 && writes_seen < 10; i++) tick();
    check_val("reached_w10", 32'(writes_seen >= 10), 1);
    pulse_capture(1'b0);
    check_val("ign_state", 32'(o_bram_state), 2);
    run_to_done();
    check_val("wr_count2",    32'(writes_seen), NPIX);
    check_val("first_din_00", 32'(first_din),   0);
    check_val("view_after",   32'(o_bram_state), 3);
    for (int i = 0; i < 80; i++) tick();
    check_val("done_once",   32'(done_cnt - dc0), 1);
    check_val("still_view",  32'(o_bram_state),   3);
    i_view_en = 1'b0;
    tick();
    check_val("idle_again", 32'(o_bram_state), 0);

    // reset mid-write, then a clean restart
    pulse_capture(1'b1);
    for (int i = 0; i < 300 && writes_seen < 20; i++) tick();
    check_val("reached_w20", 32'(writes_seen), 20);
    i_reset = 1'b0;
    exp_q.delete();
    armed     = 1'b0;
    capturing = 1'b0;
    tick();
    check_val("mid_rst_state", 32'(o_bram_state), 0);
    check_val("mid_rst_we",    32'(o_bram_we),    0);
    check_val("mid_rst_busy",  32'(o_busy),       0);
    check_val("mid_rst_addr",  32'(o_bram_addr),  0);
    i_reset = 1'b1;
    tick();
    pulse_capture(1'b1);
    run_to_done();
    check_val("restart_count", 32'(writes_seen), NPIX);
    check_val("restart_din0",  32'(first_din),   0);
    check_val("restart_q",     32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
